// File: rtl/multdiv_issue.sv
// multdiv_issue: requester side of the multiplier/divider handshake.
// Accepts one mult/div op from execute, holds its operands, pulses the
// unit's start control, stalls the pipeline until RDY or a timeout, and
// then issues a single register-file writeback (result or exception code).
module multdiv_issue #(
   parameter int WIDTH         = 32,
   parameter int TIMEOUT       = 40,
   parameter int RSTATUS_REG   = 30,
   parameter int MULT_EXC_CODE = 4,
   parameter int DIV_EXC_CODE  = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             issue_valid,
   input  logic             issue_is_div,
   input  logic [WIDTH-1:0] issue_a,
   input  logic [WIDTH-1:0] issue_b,
   input  logic [4:0]       issue_rd,
   output logic             busy,
   output logic             ctrl_MULT,
   output logic             ctrl_DIV,
   output logic [WIDTH-1:0] op_A,
   output logic [WIDTH-1:0] op_B,
   input  logic [WIDTH-1:0] data_result,
   input  logic             data_exception,
   input  logic             data_resultRDY,
   output logic             wb_valid,
   output logic [4:0]       wb_rd,
   output logic [WIDTH-1:0] wb_data
);

   // Counter must reach TIMEOUT exactly.
   localparam int CW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LAUNCH = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [CW-1:0]    TO_CNT   = CW'(TIMEOUT);
   localparam logic [4:0]       RSTAT_RD = 5'(RSTATUS_REG);
   localparam logic [WIDTH-1:0] MULT_EXC = WIDTH'(MULT_EXC_CODE);
   localparam logic [WIDTH-1:0] DIV_EXC  = WIDTH'(DIV_EXC_CODE);

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic [4:0]       rd_q, rd_d;
   logic             div_q, div_d;
   logic             ctrl_mult_q, ctrl_mult_d;
   logic             ctrl_div_q, ctrl_div_d;
   logic             wb_valid_q, wb_valid_d;
   logic [4:0]       wb_rd_q, wb_rd_d;
   logic [WIDTH-1:0] wb_data_q, wb_data_d;
   logic             exc;

   // Next-state, operand latch, start pulses and writeback formation.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      rd_d        = rd_q;
      div_d       = div_q;
      ctrl_mult_d = 1'b0;
      ctrl_div_d  = 1'b0;
      wb_valid_d  = 1'b0;
      wb_rd_d     = '0;
      wb_data_d   = '0;
      exc         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (issue_valid) begin
               op_a_d      = issue_a;
               op_b_d      = issue_b;
               rd_d        = issue_rd;
               div_d       = issue_is_div;
               // Registered start pulse lands exactly in the LAUNCH cycle.
               ctrl_div_d  = issue_is_div;
               ctrl_mult_d = ~issue_is_div;
               state_d     = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            // RDY here is a leftover from a previous op; deliberately ignored.
            cnt_d   = CW'(1);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (data_resultRDY || (cnt_q == TO_CNT)) begin
               // RDY beats a simultaneous timeout; a timeout is an exception.
               exc     = data_resultRDY ? data_exception : 1'b1;
               state_d = S_DONE;
               if (exc) begin
                  wb_valid_d = 1'b1;
                  wb_rd_d    = RSTAT_RD;
                  wb_data_d  = div_q ? DIV_EXC : MULT_EXC;
               end else if (rd_q != 5'd0) begin
                  wb_valid_d = 1'b1;
                  wb_rd_d    = rd_q;
                  wb_data_d  = data_result;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            // issue_valid here is the op being released, not a new one.
            cnt_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; synchronous reset wins over everything.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         rd_q        <= '0;
         div_q       <= 1'b0;
         ctrl_mult_q <= 1'b0;
         ctrl_div_q  <= 1'b0;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         rd_q        <= rd_d;
         div_q       <= div_d;
         ctrl_mult_q <= ctrl_mult_d;
         ctrl_div_q  <= ctrl_div_d;
         wb_valid_q  <= wb_valid_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
      end
   end

   // Stall from the accept cycle through the last WAIT cycle; DONE releases.
   always_comb begin
      busy = ((state_q == S_IDLE) && issue_valid) ||
             (state_q == S_LAUNCH) || (state_q == S_WAIT);
   end

   assign ctrl_MULT = ctrl_mult_q;
   assign ctrl_DIV  = ctrl_div_q;
   assign op_A      = op_a_q;
   assign op_B      = op_b_q;
   assign wb_valid  = wb_valid_q;
   assign wb_rd     = wb_rd_q;
   assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_multdiv_issue.sv
// Scoreboard bench for multdiv_issue: stimulus pushes expected writebacks,
// a negedge monitor pops and compares every wb_valid strobe.
module tb_multdiv_issue;

   logic        clock = 1'b0;
   logic        reset;
   logic        issue_valid, issue_is_div;
   logic [31:0] issue_a, issue_b;
   logic [4:0]  issue_rd;
   logic        busy, ctrl_MULT, ctrl_DIV;
   logic [31:0] op_A, op_B;
   logic [31:0] data_result;
   logic        data_exception, data_resultRDY;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   multdiv_issue dut (
      .clock(clock), .reset(reset),
      .issue_valid(issue_valid), .issue_is_div(issue_is_div),
      .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd),
      .busy(busy), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
      .op_A(op_A), .op_B(op_B),
      .data_result(data_result), .data_exception(data_exception),
      .data_resultRDY(data_resultRDY),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every writeback strobe must match the oldest expectation.
   always @(negedge clock) begin
      if (reset === 1'b0) begin
         if (wb_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL wb_unexpected actual rd=%0d data=%0h required none", wb_rd, wb_data);
            end else begin
               mon_e = sb.pop_front();
               if (wb_rd !== mon_e.rd || wb_data !== mon_e.data) begin
                  errors++;
                  $display("FAIL wb_contents actual rd=%0d data=%0h required rd=%0d data=%0h",
                           wb_rd, wb_data, mon_e.rd, mon_e.data);
               end
            end
         end else if (wb_valid === 1'b0) begin
            checks++;
            if (wb_rd !== 5'd0 || wb_data !== 32'd0) begin
               errors++;
               $display("FAIL wb_idle_zero actual rd=%0d data=%0h required 0", wb_rd, wb_data);
            end
         end
      end
   end

   // One full op. rdy_cyc=0 means the unit never answers (timeout path).
   task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int rdy_cyc, input logic [31:0] res,
                         input logic exc, input logic launch_rdy, input logic hold,
                         input logic exp_v, input logic [4:0] exp_rd, input logic [31:0] exp_d);
      int   nwait;
      exp_t e;
      // Accept cycle (IDLE)
      @(negedge clock);
      issue_valid = 1'b1; issue_is_div = is_div; issue_a = a; issue_b = b; issue_rd = rd;
      data_resultRDY = 1'b0; data_exception = 1'b0;
      #1;
      chk("accept_busy", {31'd0, busy}, 32'd1);
      chk("accept_no_start", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
      if (exp_v) begin
         e.rd = exp_rd; e.data = exp_d;
         sb.push_back(e);
      end
      // LAUNCH
      @(negedge clock);
      issue_valid = hold; issue_a = 32'hffff_ffff; issue_b = 32'hffff_ffff;
      data_resultRDY = launch_rdy; data_result = 32'hdead; data_exception = 1'b0;
      #1;
      chk("launch_div", {31'd0, ctrl_DIV}, {31'd0, is_div});
      chk("launch_mult", {31'd0, ctrl_MULT}, {31'd0, ~is_div});
      chk("launch_busy", {31'd0, busy}, 32'd1);
      chk("launch_opA", op_A, a);
      chk("launch_opB", op_B, b);
      // WAIT
      nwait = (rdy_cyc == 0) ? 40 : rdy_cyc;
      for (int k = 1; k <= nwait; k++) begin
         @(negedge clock);
         data_resultRDY = (k == rdy_cyc); data_result = res; data_exception = exc;
         #1;
         chk("wait_busy", {31'd0, busy}, 32'd1);
         chk("wait_no_start", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
         chk("wait_ops", {op_A ^ a} | {op_B ^ b}, 32'd0);
      end
      // DONE
      @(negedge clock);
      data_resultRDY = 1'b0; data_exception = 1'b0; issue_valid = hold;
      #1;
      chk("done_busy", {31'd0, busy}, 32'd0);
      chk("done_wb_valid", {31'd0, wb_valid}, {31'd0, exp_v});
      chk("done_sb_drained", sb.size(), 32'd0);
      chk("done_opA", op_A, a);
   endtask

   initial begin
      reset = 1'b1; issue_valid = 1'b0; issue_is_div = 1'b0;
      issue_a = '0; issue_b = '0; issue_rd = '0;
      data_result = '0; data_exception = 1'b0; data_resultRDY = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ctrl", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
      chk("rst_wb", {26'd0, wb_valid, wb_rd}, 32'd0);
      chk("rst_ops", op_A | op_B | wb_data, 32'd0);
      reset = 1'b0;

      // Div 100/7, RDY in WAIT cycle 33
      run_op(1'b1, 32'd100, 32'd7, 5'd5, 33, 32'd14, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'd14);
      // Mult exception
      run_op(1'b0, 32'h4000_0000, 32'd4, 5'd3, 5, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd30, 32'd4);
      // Divide by zero, stale RDY in LAUNCH
      run_op(1'b1, 32'd9, 32'd0, 5'd2, 3, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd30, 32'd5);
      // Timeout: no RDY ever
      run_op(1'b1, 32'd50, 32'd5, 5'd4, 0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd30, 32'd5);
      // RDY in WAIT cycle 40 beats the timeout
      run_op(1'b1, 32'd50, 32'd5, 5'd4, 40, 32'd10, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 32'd10);

      // Reset mid-op in WAIT cycle 10
      @(negedge clock);
      issue_valid = 1'b1; issue_is_div = 1'b1; issue_a = 32'd77; issue_b = 32'd3; issue_rd = 5'd8;
      @(negedge clock);
      issue_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clock);
         if (k == 10) reset = 1'b1;
      end
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_ctrl", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
      chk("midrst_wb", {26'd0, wb_valid, wb_rd}, 32'd0);
      chk("midrst_ops", op_A | op_B | wb_data, 32'd0);
      @(negedge clock);
      data_resultRDY = 1'b1; data_result = 32'd25;
      @(negedge clock);
      data_resultRDY = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      chk("late_rdy_busy", {31'd0, busy}, 32'd0);
      run_op(1'b0, 32'd6, 32'd7, 5'd9, 1, 32'd42, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'd42);

      // Back-to-back: mult rd=0 with issue held through DONE, then div 12/4
      run_op(1'b0, 32'd2, 32'd3, 5'd0, 2, 32'd6, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
      run_op(1'b1, 32'd12, 32'd4, 5'd7, 4, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'd3);
      @(negedge clock);
      issue_valid = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      chk("end_sb_empty", sb.size(), 32'd0);
      chk("end_idle_busy", {31'd0, busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
